// File: rtl/iter_div_pkg.sv
// iter_div_pkg: shared divider constants, state encoding and operand helpers
package iter_div_pkg;
    localparam int DIV_WD     = 32;
    localparam int DIV_RES_WD = 64;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [DIV_WD-1:0] abs32(input logic [DIV_WD-1:0] v, input logic s);
        return (s && v[DIV_WD-1]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [DIV_WD-1:0] neg_if(input logic [DIV_WD-1:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [DIV_RES_WD-1:0] pack_res(input logic [DIV_WD-1:0] rem, input logic [DIV_WD-1:0] quo);
        return {rem, quo};
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift/subtract step against |divisor|
module div_step (
    input  logic [32:0] pr_hi_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic        q_o
);
    assign q_o   = pr_hi_i >= {1'b0, dvs_i};
    assign rem_o = q_o ? 32'(pr_hi_i - {1'b0, dvs_i}) : pr_hi_i[31:0];
endmodule

// File: rtl/iter_div.sv
// iter_div: 32-step restoring divider for DIV/DIVU returning {remainder, quotient}
module iter_div
    import iter_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        div_en,
    input  logic        div_signed,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic        div_ack,
    input  logic        cancel,
    output logic        busy,
    output logic        complete,
    output logic [63:0] div_res
);
    div_state_e state_q, state_d;
    logic [4:0]  cnt_q;
    logic [63:0] pr_q;
    logic [31:0] dvs_q;
    logic [31:0] src1_q;
    logic        q_neg_q, r_neg_q, dz_q;
    logic [63:0] res_q;
    logic [31:0] rem_nx;
    logic        q_bit;
    logic [31:0] quo_nx;
    logic [63:0] res_fix;
    logic        start;

    div_step u_step (
        .pr_hi_i(pr_q[63:31]),
        .dvs_i  (dvs_q),
        .rem_o  (rem_nx),
        .q_o    (q_bit)
    );

    assign start    = state_q == DIV_IDLE && div_en && !cancel;
    assign quo_nx   = {pr_q[30:0], q_bit};
    assign res_fix  = dz_q ? pack_res(src1_q, 32'hFFFF_FFFF)
                           : pack_res(neg_if(rem_nx, r_neg_q), neg_if(quo_nx, q_neg_q));
    assign busy     = state_q != DIV_IDLE;
    assign complete = state_q == DIV_DONE;
    assign div_res  = res_q;

    // next state: cancel dominates, then start / last step / acknowledge
    always_comb begin
        state_d = state_q;
        if (cancel)
            state_d = DIV_IDLE;
        else
            unique case (state_q)
                DIV_IDLE: state_d = div_en ? DIV_CALC : DIV_IDLE;
                DIV_CALC: state_d = (cnt_q == 5'd31) ? DIV_DONE : DIV_CALC;
                DIV_DONE: state_d = div_ack ? DIV_IDLE : DIV_DONE;
                default:  state_d = DIV_IDLE;
            endcase
    end

    // state, operand capture, iteration and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            dvs_q   <= '0;
            src1_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                cnt_q   <= '0;
                pr_q    <= {32'd0, abs32(div_src1, div_signed)};
                dvs_q   <= abs32(div_src2, div_signed);
                src1_q  <= div_src1;
                q_neg_q <= div_signed & (div_src1[31] ^ div_src2[31]);
                r_neg_q <= div_signed & div_src1[31];
                dz_q    <= div_src2 == 32'd0;
            end else if (state_q == DIV_CALC) begin
                cnt_q <= cnt_q + 5'd1;
                pr_q  <= {rem_nx, quo_nx};
                if (cnt_q == 5'd31 && !cancel)
                    res_q <= res_fix;
            end
        end
    end
endmodule

// File: doc/iter_div.md
# iter_div

Iterative 32-bit radix-2 restoring divider that serves MIPS DIV/DIVU for the execute stage, one instance per issue slot. The execute stage starts an operation, stalls on `complete`, and acknowledges the result when the instruction leaves the stage. The divider returns a 64-bit {remainder, quotient} result, which is later written to HI/LO. A pipeline flush (`cancel`) aborts it at any point.

## Interface
Parameters:
- none; the width is fixed at 32.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `div_en` in 1 — a divide is requested; held high by the execute stage until acknowledged.
- `div_signed` in 1 — 1 selects DIV, 0 selects DIVU; sampled at start.
- `div_src1` in 32 — dividend; sampled at start.
- `div_src2` in 32 — divisor; sampled at start.
- `div_ack` in 1 — the result has been consumed (execute stage ready-go and allowin).
- `cancel` in 1 — flush; aborts the current operation.
- `busy` out 1 — high in CALC and DONE.
- `complete` out 1 — the result in `div_res` is valid (DONE state).
- `div_res` out 64 — {remainder[63:32], quotient[31:0]}.

## Operation
States:
- IDLE: if `div_en` is high and `cancel` is low, latch the operands, the sign flags and the absolute values; clear the counter; go to CALC.
- CALC: one restoring step per cycle, on a 64-bit partial remainder with a shift/subtract against |divisor|; 32 steps, counter 0..31. On the step with counter == 31, apply the sign fix, load `div_res`, and go to DONE.
- DONE: `complete` = 1 and `div_res` is held. On `div_ack`, go to IDLE. Without `div_ack`, stay in DONE indefinitely (downstream back-pressure).

Cancel:
- `cancel` in any state means IDLE next cycle.
- It has priority over `div_en` and `div_ack` in the same cycle.
- `div_res` keeps its last value.

Start rules:
- No start is possible in the cycle of `div_ack`. A back-to-back divide is sampled in IDLE on the following cycle.

Operand handling:
- Operand changes after start are ignored.
- `div_en` falling during CALC without `cancel` is ignored (the execute stage guarantees this does not happen).

Arithmetic rules:
- Signed mode: the quotient is negative iff the operand signs differ; the remainder takes the dividend sign.
- Unsigned mode: no sign fix.
- 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0 (two's-complement wrap, no exception).
- Divisor 0, either mode: quotient 0xFFFFFFFF, remainder = original `div_src1`, no exception, normal latency. The signed path must force this value, not apply the sign fix to it.

## Timing
Reset values:
- state IDLE, `busy` 0, `complete` 0, `div_res` 0, counter 0.

Latency:
- `div_en` sampled high in IDLE at cycle t: CALC runs t+1..t+32, and `complete` = 1 from cycle t+33.
- `div_ack` at cycle d: `complete` = 0 at d+1.
- Minimum spacing between starts: 34 cycles.

Output sourcing:
- `complete` and `busy` are decoded from registered state only.
- `div_res` is a register; it is stable for the entire DONE state and retained in IDLE.

`cancel`:
- At cycle c, `busy` and `complete` are 0 at c+1.
- The first new start can be sampled at c+1.

`reset` mid-operation:
- Identical to `cancel`, and additionally `div_res` is cleared.

## Structure
Shared constants go in `mycpu.h`:
- state encodings `DIV_IDLE`, `DIV_CALC`, `DIV_DONE` (2 bits);
- `DIV_RES_WD` = 64;
- the field order {remainder, quotient}, which the HI/LO writeback also uses.

Sub-modules:
- At most one, `div_step`: a combinational restoring step taking the partial remainder and divisor and producing the next partial remainder and the quotient bit.
- Everything else (FSM, counter, sign fix) lives in `iter_div`, which is instantiated inside `alu`.

## Test plan
- Unsigned: 100 / 7, `div_signed` = 0 → `div_res` = {0x00000002, 0x0000000E}; `complete` rises exactly 33 cycles after the start sample.
- Signed: -7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Corner cases: 0x80000000 / 0xFFFFFFFF signed → {0, 0x80000000}. 0x12345678 / 0, either mode → {0x12345678, 0xFFFFFFFF}.
- Back-pressure and back-to-back:
  - Hold `div_ack` low for 10 cycles after `complete` → `complete` and `div_res` stay stable.
  - Ack with `div_en` kept high and new operands 9 / 3 → one IDLE cycle, then a new start; result {0, 3} 33 cycles later.
- `cancel`:
  - At CALC step 15 → IDLE next cycle, `complete` never asserts, old `div_res` retained.
  - `cancel` and `div_en` together in IDLE → no start.
  - `cancel` in DONE together with `div_ack` → IDLE.
- `reset`: asserted mid-CALC and again in DONE → next cycle all outputs 0. Randomised signed/unsigned operands are checked against a reference model (`/`, `%` with truncation toward zero).
